// File: rtl/board_refresh_ctrl_pkg.sv
// Shared constants, FSM state type and line-clear point values for the board refresh sequencer.
package board_refresh_ctrl_pkg;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int AW = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CHK,
    S_FILL,
    S_WIPE,
    S_DONE
  } state_t;

  localparam logic [15:0] PTS_1 = 16'd1;
  localparam logic [15:0] PTS_2 = 16'd3;
  localparam logic [15:0] PTS_3 = 16'd5;
  localparam logic [15:0] PTS_4 = 16'd8;

endpackage

// File: rtl/board_refresh_ctrl_score_accum.sv
// Score register: adds line-clear points on i_add, saturating at 0xFFFF; i_clr zeroes it.
// One-cycle update latency; no backpressure.
module score_accum
  import board_refresh_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [2:0]  i_cnt,
  output logic [15:0] o_score
);

  logic [15:0] r_score;
  logic [15:0] w_pts;
  logic [16:0] w_sum;

  // Counts above four only arise from illegal boards; they earn the four-line value.
  always_comb begin
    case (i_cnt)
      3'd0:    w_pts = 16'd0;
      3'd1:    w_pts = PTS_1;
      3'd2:    w_pts = PTS_2;
      3'd3:    w_pts = PTS_3;
      default: w_pts = PTS_4;
    endcase
  end

  assign w_sum = {1'b0, r_score} + {1'b0, w_pts};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_score <= '0;
    end else if (i_clr) begin
      r_score <= '0;
    end else if (i_add) begin
      r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/board_refresh_ctrl.sv
// Board row RAM sequencer: bottom-up scan removes full rows, compacts the rest, zero-fills the top.
// Refresh pass takes 2H+C+1 cycles, wipe H+1; start pulses are dropped while busy.
module board_refresh_ctrl
  import board_refresh_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          refresh,
  input  logic          clear_all,
  input  logic [AW-1:0] disp_addr,
  input  logic [W-1:0]  ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [W-1:0]  ram_wdata,
  output logic          busy,
  output logic          refresh_done,
  output logic [2:0]    lines_cleared,
  output logic [15:0]   score
);

  localparam logic [AW-1:0] ROW_LAST = AW'(H - 1);

  state_t        r_state;
  logic [AW-1:0] r_rd_row;
  logic [AW-1:0] r_wr_row;
  logic [2:0]    r_cnt;
  logic [2:0]    r_fcnt;
  logic          r_wipe;
  logic          r_done;
  logic [2:0]    r_lines;

  logic          w_full;
  logic [2:0]    w_cnt_nxt;
  logic          w_chk_wr;
  logic          w_add;
  logic          w_clr;

  assign w_full    = (ram_rdata == {W{1'b1}});
  assign w_cnt_nxt = (w_full && r_cnt != 3'd7) ? r_cnt + 3'd1 : r_cnt;
  // Rows below the first full row are already in place, so they are not rewritten.
  assign w_chk_wr  = (r_state == S_CHK) && !w_full && (r_rd_row != r_wr_row);

  // The write in CHK must use ram_rdata of the same cycle, so the port is driven combinationally.
  always_comb begin
    ram_addr  = r_rd_row;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (r_state)
      S_IDLE: ram_addr = disp_addr;
      S_CHK: begin
        if (w_chk_wr) begin
          ram_addr  = r_wr_row;
          ram_we    = 1'b1;
          ram_wdata = ram_rdata;
        end
      end
      S_FILL: begin
        ram_addr = r_wr_row;
        ram_we   = 1'b1;
      end
      S_WIPE: ram_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_rd_row <= ROW_LAST;
      r_wr_row <= ROW_LAST;
      r_cnt    <= '0;
      r_fcnt   <= '0;
      r_wipe   <= 1'b0;
      r_done   <= 1'b0;
      r_lines  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_all) begin
            r_state  <= S_WIPE;
            r_rd_row <= '0;
            r_wipe   <= 1'b1;
            r_lines  <= '0;
          end else if (refresh) begin
            r_state  <= S_RD;
            r_rd_row <= ROW_LAST;
            r_wr_row <= ROW_LAST;
            r_cnt    <= '0;
            r_wipe   <= 1'b0;
          end
        end
        S_RD: r_state <= S_CHK;
        S_CHK: begin
          r_cnt <= w_cnt_nxt;
          if (!w_full) r_wr_row <= r_wr_row - 1'b1;
          if (r_rd_row == '0) begin
            r_fcnt <= '0;
            if (w_cnt_nxt != '0) begin
              r_state <= S_FILL;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_lines <= '0;
            end
          end else begin
            r_rd_row <= r_rd_row - 1'b1;
            r_state  <= S_RD;
          end
        end
        S_FILL: begin
          r_wr_row <= r_wr_row - 1'b1;
          r_fcnt   <= r_fcnt + 3'd1;
          if (r_fcnt == r_cnt - 3'd1) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_lines <= r_cnt;
          end
        end
        S_WIPE: begin
          if (r_rd_row == ROW_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_rd_row <= r_rd_row + 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_add = (r_state == S_DONE) && !r_wipe;
  assign w_clr = (r_state == S_IDLE) && clear_all;

  score_accum u_score (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_clr),
    .i_add   (w_add),
    .i_cnt   (r_cnt),
    .o_score (score)
  );

  assign busy          = (r_state != S_IDLE);
  assign refresh_done  = r_done;
  assign lines_cleared = r_lines;

endmodule

// File: tb/tb_board_refresh_ctrl.sv
// Bench for board_refresh_ctrl: behavioural row RAM, table of refresh passes, wipe/reset sequences,
// and a standalone score accumulator driven up to saturation.
module tb_board_refresh_ctrl;
  import board_refresh_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          refresh = 1'b0;
  logic          clear_all = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [W-1:0]  ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata;
  logic          busy;
  logic          refresh_done;
  logic [2:0]    lines_cleared;
  logic [15:0]   score;

  logic          sa_clr = 1'b0;
  logic          sa_add = 1'b0;
  logic [2:0]    sa_cnt = '0;
  logic [15:0]   sa_score;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  board_refresh_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .refresh       (refresh),
    .clear_all     (clear_all),
    .disp_addr     (disp_addr),
    .ram_rdata     (ram_rdata),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .busy          (busy),
    .refresh_done  (refresh_done),
    .lines_cleared (lines_cleared),
    .score         (score)
  );

  score_accum u_sa (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (sa_clr),
    .i_add   (sa_add),
    .i_cnt   (sa_cnt),
    .o_score (sa_score)
  );

  // Row RAM with one-cycle read latency; the bench preloads it through the ld_* port.
  logic [W-1:0]  mem [H];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0]  ld_dat = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_dat;
    else if (ram_we && int'(ram_addr) < H) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (int'(ram_addr) < H) ? mem[ram_addr] : '0;
  end

  typedef struct {
    logic [H-1:0] full;
    logic [H-1:0] part;
    logic [W-1:0] val;
    int           lines;
    int           done;
    int           pts;
    int           writes;
  } vec_t;

  vec_t         vecs [5];
  logic [W-1:0] init_b [H];
  logic [W-1:0] exp_b  [H];
  int           exp_score = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic preload(input int i);
    @(negedge clk);
    ld_en = 1'b1;
    for (int r = 0; r < H; r++) begin
      if (vecs[i].full[r])      init_b[r] = {W{1'b1}};
      else if (vecs[i].part[r]) init_b[r] = vecs[i].val;
      else                      init_b[r] = '0;
      ld_addr = AW'(r);
      ld_dat  = init_b[r];
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // Expected board: surviving rows keep their order, packed against the bottom.
  task automatic model_compact();
    int k;
    k = H - 1;
    for (int r = 0; r < H; r++) exp_b[r] = '0;
    for (int r = H - 1; r >= 0; r--) begin
      if (init_b[r] != {W{1'b1}}) begin
        exp_b[k] = init_b[r];
        k--;
      end
    end
  endtask

  task automatic board_check(input string nm);
    int bad;
    bad = 0;
    for (int r = 0; r < H; r++) if (mem[r] !== exp_b[r]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic run_pass(input logic rf, input logic ca, input int mid,
                          output int dc, output int nw, output logic b1);
    int cyc;
    @(negedge clk);
    refresh   = rf;
    clear_all = ca;
    nw  = 0;
    dc  = -1;
    b1  = 1'b0;
    cyc = 0;
    while (cyc < 200 && dc < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) b1 = busy;
      if (ram_we) nw++;
      if (refresh_done) dc = cyc;
      refresh   = (cyc == mid);
      clear_all = 1'b0;
    end
    refresh = 1'b0;
  endtask

  task automatic do_vector(input int i);
    int   dc, nw;
    logic b1;
    preload(i);
    model_compact();
    run_pass(1'b1, 1'b0, 0, dc, nw, b1);
    chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].done);
    chk($sformatf("v%0d_busy_cyc1", i), b1, 1);
    chk($sformatf("v%0d_lines", i), lines_cleared, vecs[i].lines);
    chk($sformatf("v%0d_writes", i), nw, vecs[i].writes);
    @(negedge clk);
    exp_score = exp_score + vecs[i].pts;
    chk($sformatf("v%0d_score", i), score, exp_score);
    chk($sformatf("v%0d_idle", i), busy, 0);
    board_check($sformatf("v%0d_board", i));
  endtask

  task automatic sa_pulse(input logic [2:0] c);
    @(negedge clk);
    sa_cnt = c;
    sa_add = 1'b1;
    @(negedge clk);
    sa_add = 1'b0;
  endtask

  initial begin
    int   dc, nw;
    logic b1;

    vecs[0] = '{20'h00000, 20'h00000, 10'h000, 0, 41, 0, 0};
    vecs[1] = '{20'h80000, 20'h40000, 10'h001, 1, 42, 1, 20};
    vecs[2] = '{20'hAA000, 20'h54000, 10'h155, 4, 45, 8, 20};
    vecs[3] = '{20'hC0000, 20'h00001, 10'h2AA, 2, 43, 3, 20};
    vecs[4] = '{20'h00421, 20'h80002, 10'h0F0, 3, 44, 5, 11};

    disp_addr = 5'd3;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_done", refresh_done, 0);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_score", score, 0);
    chk("rst_addr_pass", ram_addr, 3);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) do_vector(i);

    // Reset asserted mid-pass
    preload(2);
    disp_addr = 5'd7;
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_wdata", ram_wdata, 0);
    chk("mid_rst_lines", lines_cleared, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_addr", ram_addr, 7);
    @(negedge clk);
    rstn = 1'b1;
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_we) nw++;
    end
    chk("mid_rst_no_writes", nw, 0);
    disp_addr = 5'd13;
    #1;
    chk("mid_rst_addr2", ram_addr, 13);
    exp_score = 0;

    do_vector(1);

    // clear_all together with refresh, plus a refresh pulse during the wipe
    preload(2);
    for (int r = 0; r < H; r++) exp_b[r] = '0;
    run_pass(1'b1, 1'b1, 5, dc, nw, b1);
    chk("wipe_done_cycle", dc, 21);
    chk("wipe_writes", nw, 20);
    chk("wipe_lines", lines_cleared, 0);
    @(negedge clk);
    chk("wipe_score", score, 0);
    board_check("wipe_board");
    b1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy) b1 = 1'b1;
    end
    chk("wipe_refresh_ignored", b1, 0);

    // Standalone accumulator driven to saturation
    @(negedge clk);
    sa_cnt = 3'd4;
    sa_add = 1'b1;
    repeat (8191) @(negedge clk);
    sa_add = 1'b0;
    chk("sa_8191x8", sa_score, 65528);
    sa_pulse(3'd2);
    sa_pulse(3'd1);
    chk("sa_fffc", sa_score, 16'hFFFC);
    sa_pulse(3'd4);
    chk("sa_sat", sa_score, 16'hFFFF);
    sa_pulse(3'd7);
    chk("sa_sat_hold", sa_score, 16'hFFFF);
    @(negedge clk);
    sa_clr = 1'b1;
    @(negedge clk);
    sa_clr = 1'b0;
    chk("sa_clr", sa_score, 0);
    sa_pulse(3'd7);
    chk("sa_cnt7", sa_score, 8);
    sa_pulse(3'd3);
    chk("sa_cnt3", sa_score, 13);
    sa_pulse(3'd0);
    chk("sa_cnt0", sa_score, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
